// File: rtl/fu_dispatch_queue.sv
// In-order dispatch queue between decode and the functional units.
// Issues the head entry to its FU class when ready; tracks non-pipelined multiplier occupancy.
module fu_dispatch_queue #(
  parameter int DEPTH    = 8,
  parameter int MULT_LAT = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         in_valid,
  input  logic [31:0]                  in_inst,
  input  logic [31:0]                  in_pc,
  input  logic [2:0]                   in_class,
  output logic                         in_ready,
  input  logic                         alu_ready,
  input  logic                         mem_ready,
  input  logic                         br_ready,
  output logic                         alu_issue,
  output logic                         mult_issue,
  output logic                         mem_issue,
  output logic                         br_issue,
  output logic [31:0]                  issue_inst,
  output logic [31:0]                  issue_pc,
  output logic                         illegal_drop,
  output logic                         mult_busy,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int MW = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;

  logic [31:0]   inst_q  [DEPTH];
  logic [31:0]   inst_d  [DEPTH];
  logic [31:0]   pc_q    [DEPTH];
  logic [31:0]   pc_d    [DEPTH];
  logic [2:0]    class_q [DEPTH];
  logic [2:0]    class_d [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [MW-1:0] mult_cnt_q, mult_cnt_d;

  logic          not_empty;
  logic          enq;
  logic          deq;
  logic [2:0]    head_class;

  always_comb begin
    not_empty    = (count_q != '0);
    in_ready     = (count_q != CW'(DEPTH));
    mult_busy    = (mult_cnt_q != '0);
    head_class   = class_q[head_q];
    issue_inst   = not_empty ? inst_q[head_q] : '0;
    issue_pc     = not_empty ? pc_q[head_q]   : '0;
    count        = count_q;

    alu_issue    = 1'b0;
    mult_issue   = 1'b0;
    mem_issue    = 1'b0;
    br_issue     = 1'b0;
    illegal_drop = 1'b0;
    if (not_empty) begin
      case (head_class)
        3'b001:  alu_issue    = alu_ready;
        3'b010:  mult_issue   = !mult_busy;
        3'b011:  mem_issue    = mem_ready;
        3'b100:  br_issue     = br_ready;
        default: illegal_drop = 1'b1;
      endcase
    end
    deq = alu_issue | mult_issue | mem_issue | br_issue | illegal_drop;
    enq = in_valid & in_ready & ~flush;

    inst_d  = inst_q;
    pc_d    = pc_q;
    class_d = class_q;
    if (enq) begin
      inst_d[tail_q]  = in_inst;
      pc_d[tail_q]    = in_pc;
      class_d[tail_q] = in_class;
    end

    head_d  = deq ? head_q + PW'(1) : head_q;
    tail_d  = enq ? tail_q + PW'(1) : tail_q;
    count_d = count_q + CW'(enq) - CW'(deq);
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end

    // Flush leaves the multiplier counter alone: an in-flight multiply still owns the unit.
    if (mult_issue)
      mult_cnt_d = MW'(MULT_LAT - 1);
    else if (mult_cnt_q != '0)
      mult_cnt_d = mult_cnt_q - MW'(1);
    else
      mult_cnt_d = mult_cnt_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      inst_q     <= '{default: '0};
      pc_q       <= '{default: '0};
      class_q    <= '{default: '0};
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      mult_cnt_q <= '0;
    end else begin
      inst_q     <= inst_d;
      pc_q       <= pc_d;
      class_q    <= class_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      mult_cnt_q <= mult_cnt_d;
    end
  end

endmodule

// File: tb/tb_fu_dispatch_queue.sv
// Randomized scoreboard bench for fu_dispatch_queue: driver feeds a queue model,
// monitor derives expected issue behaviour from model contents and FU readiness.
module tb_fu_dispatch_queue;

  localparam int DEPTH    = 8;
  localparam int MULT_LAT = 4;
  localparam int CW       = $clog2(DEPTH + 1);

  logic          clock = 1'b0;
  logic          reset, flush, in_valid;
  logic [31:0]   in_inst, in_pc;
  logic [2:0]    in_class;
  logic          in_ready;
  logic          alu_ready, mem_ready, br_ready;
  logic          alu_issue, mult_issue, mem_issue, br_issue;
  logic [31:0]   issue_inst, issue_pc;
  logic          illegal_drop, mult_busy;
  logic [CW-1:0] count;

  fu_dispatch_queue #(.DEPTH(DEPTH), .MULT_LAT(MULT_LAT)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_inst(in_inst), .in_pc(in_pc), .in_class(in_class),
    .in_ready(in_ready),
    .alu_ready(alu_ready), .mem_ready(mem_ready), .br_ready(br_ready),
    .alu_issue(alu_issue), .mult_issue(mult_issue), .mem_issue(mem_issue), .br_issue(br_issue),
    .issue_inst(issue_inst), .issue_pc(issue_pc),
    .illegal_drop(illegal_drop), .mult_busy(mult_busy), .count(count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [2:0]  cls;
  } ent_t;

  typedef struct {
    int cycles;
    int p_valid;
    int p_ready;
    int p_flush;
    int p_reset;
    int cmode;
  } phase_t;

  ent_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   free_at = 0;
  bit   checking = 0;
  bit   done = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endfunction

  // Monitor: samples mid-cycle and pops the scoreboard whenever the head leaves.
  always @(negedge clock) begin
    if (checking && !done) begin
      bit   busy;
      logic [4:0] e_flags;
      ent_t h;
      cyc++;
      busy    = (cyc < free_at);
      e_flags = '0;
      check("mult_busy", 64'(mult_busy), 64'(busy));
      check("count", 64'(count), 64'(exp_q.size()));
      check("in_ready", 64'(in_ready), 64'(exp_q.size() != DEPTH));
      if (exp_q.size() > 0) begin
        h = exp_q[0];
        case (h.cls)
          3'd1:    e_flags[4] = alu_ready;
          3'd2:    e_flags[3] = !busy;
          3'd3:    e_flags[2] = mem_ready;
          3'd4:    e_flags[1] = br_ready;
          default: e_flags[0] = 1'b1;
        endcase
        check("issue_inst", 64'(issue_inst), 64'(h.inst));
        check("issue_pc", 64'(issue_pc), 64'(h.pc));
      end else begin
        check("empty_inst", 64'(issue_inst), 64'd0);
        check("empty_pc", 64'(issue_pc), 64'd0);
      end
      check("issue_flags", 64'({alu_issue, mult_issue, mem_issue, br_issue, illegal_drop}),
            64'(e_flags));
      if (e_flags != '0) void'(exp_q.pop_front());
      if (e_flags[3]) free_at = cyc + MULT_LAT;
    end
  end

  function automatic logic [2:0] pick_class(int cmode);
    int r;
    case (cmode)
      1: return 3'd1;
      2: return 3'd2;
      3: return ($urandom_range(0, 1) == 0) ? 3'd3 : 3'd1;
      default: begin
        r = $urandom_range(0, 19);
        if (r < 5)       return 3'd1;
        else if (r < 9)  return 3'd2;
        else if (r < 13) return 3'd3;
        else if (r < 16) return 3'd4;
        else begin
          r = $urandom_range(0, 3);
          return (r == 0) ? 3'd0 : 3'(4 + r);
        end
      end
    endcase
  endfunction

  function automatic bit chance(int pct);
    return $urandom_range(0, 99) < pct;
  endfunction

  phase_t phases[7] = '{
    '{30,  100, 0,   0, 0, 1},   // fill until full, extra valids ignored
    '{40,  100, 100, 0, 0, 1},   // continuous enqueue + issue, pointer wrap
    '{40,  80,  100, 0, 0, 2},   // back-to-back multiplies
    '{60,  70,  40,  0, 0, 3},   // mem stalls with alu behind
    '{250, 60,  60,  6, 0, 0},   // mixed classes with flushes
    '{250, 75,  50,  3, 2, 0},   // mixed with mid-run resets
    '{80,  50,  80,  0, 0, 0}
  };

  initial begin
    bit   last_reset, last_flush, last_enq;
    ent_t last_ent, e;
    int   pc_seq;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0;
    in_inst = '0; in_pc = '0; in_class = '0;
    alu_ready = 1'b0; mem_ready = 1'b0; br_ready = 1'b0;
    last_reset = 1'b1; last_flush = 1'b0; last_enq = 1'b0;
    pc_seq = 'h40;
    last_ent = '0;
    repeat (2) @(posedge clock);
    #1;
    checking = 1'b1;

    foreach (phases[p]) begin
      for (int c = 0; c < phases[p].cycles; c++) begin
        // Apply the previous cycle's edge effects to the model.
        if (last_reset) begin
          exp_q.delete();
          free_at = 0;
        end else if (last_flush) begin
          exp_q.delete();
        end else if (last_enq) begin
          exp_q.push_back(last_ent);
        end

        reset     = (p == 0 && c == 0) ? 1'b1 : chance(phases[p].p_reset);
        flush     = chance(phases[p].p_flush);
        in_valid  = chance(phases[p].p_valid);
        pc_seq    = pc_seq + 4;
        e.inst    = $urandom;
        e.pc      = 32'(pc_seq);
        e.cls     = pick_class(phases[p].cmode);
        in_inst   = e.inst;
        in_pc     = e.pc;
        in_class  = e.cls;
        alu_ready = (p == 0) ? 1'b0 : chance(phases[p].p_ready);
        mem_ready = chance(phases[p].p_ready);
        br_ready  = chance(phases[p].p_ready);

        last_reset = reset;
        last_flush = flush;
        last_enq   = in_valid && !flush && !reset && (exp_q.size() != DEPTH);
        last_ent   = e;
        @(posedge clock);
        #1;
      end
    end

    reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
    @(negedge clock);
    done = 1'b1;
    if (n_cmp < 12) begin
      n_bad++;
      $display("FAIL too_few_comparisons: got %0d expected at least 12", n_cmp);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fu_dispatch_queue.md
Name: fu_dispatch_queue

Overview:
- In-order buffer between the ID-stage decoder and the functional units.
- Accepts instructions already tagged with the decoder's 3-bit FU class (001 ALU, 010 MULT, 011 MEM, 100 BRANCH/CTRL) and holds them in a circular queue.
- Issues the head entry to the matching FU when that FU is ready, and tracks the occupancy of the non-pipelined multiplier.
- This block is the consumer end of the decoder's class output.

Parameters:
- DEPTH, 8, number of queue entries; power of 2, ≥2.
- MULT_LAT, 4, multiplier occupancy in cycles, ≥1.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous clear of all queue entries (mispredict).
- in_valid  in  1  enqueue request.
- in_inst  in  32  instruction word (INST).
- in_pc  in  32  instruction PC.
- in_class  in  3  FU class from decoder.
- in_ready  out  1  queue can accept an entry this cycle.
- alu_ready, mem_ready, br_ready  in  1 each  FU can accept an issue this cycle.
- alu_issue, mult_issue, mem_issue, br_issue  out  1 each  head issued to that FU this cycle; at most one high.
- issue_inst  out  32  head instruction word.
- issue_pc  out  32  head PC.
- illegal_drop  out  1  head had an unsupported class and was discarded this cycle.
- mult_busy  out  1  multiplier occupied.
- count  out  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Storage: DEPTH entries of {inst, pc, class}. Head and tail pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. count is a separate register.
- Reset (synchronous, highest priority): head=tail=0, count=0, mult counter=0.
  - Resulting outputs: in_ready=1, all issue flags=0, illegal_drop=0, mult_busy=0.
  - issue_inst and issue_pc read 0 while empty (storage cleared on reset).
- Enqueue:
  - in_ready = (count != DEPTH). It is not dequeue-aware: when full, no enqueue even if the head issues in the same cycle.
  - Enqueue happens when in_valid & in_ready. The entry is written at tail and tail advances.
  - An entry enqueued into an empty queue becomes head on the next cycle, so minimum enqueue-to-issue latency is 1 cycle.
- Issue (combinational from registered head entry and ready inputs, only when count != 0):
  - class 001: alu_issue = alu_ready.
  - class 010: mult_issue = !mult_busy.
  - class 011: mem_issue = mem_ready.
  - class 100: br_issue = br_ready.
  - class 000 or 101–111: illegal_drop = 1 unconditionally.
  - Any issue or illegal_drop dequeues: head advances at the edge. Otherwise the head stalls and nothing behind it issues (strict in-order).
- Occupancy: count' = count + enq − deq. Simultaneous enq and deq leaves count unchanged.
- Multiplier counter:
  - On mult_issue, the counter loads MULT_LAT−1. Otherwise it decrements while nonzero.
  - mult_busy = (counter != 0). With MULT_LAT=1, mult_busy is never asserted.
- Flush (below reset in priority):
  - Sets head=tail=0 and count=0, and suppresses any enqueue in the same cycle.
  - Issue outputs computed combinationally in the flush cycle still assert, so an FU may accept the head; the flush itself takes effect at the edge.
  - Flush does not clear the multiplier counter, because the in-flight multiply still occupies the unit.
- Empty queue: all issue flags and illegal_drop are 0, regardless of ready inputs.
- Wrap: tail at DEPTH−1 followed by an enqueue goes to 0; the same rule applies to head.
- Mid-operation reset: the cycle after reset deasserts behaves exactly as after power-on reset.

Test Plan:
- Reset then enqueue ADD (class 001, pc 0x100) with alu_ready=1 → alu_issue=1 on the next cycle with issue_pc=0x100, then count returns to 0.
- Enqueue MUL, MUL back-to-back, MULT_LAT=4 → first mult_issue at cycle 1, mult_busy high for cycles 2–4, second mult_issue at cycle 5.
- Enqueue 8 entries with alu_ready=0 → count=8, in_ready=0. A 9th in_valid is ignored. Then alu_ready=1 and enqueue continuously → 8 issues in PC order, and the pointers wrap correctly through index 0.
- Head class 011 with mem_ready=0 and a class-001 entry behind it with alu_ready=1 → no issue until mem_ready=1, then mem_issue followed by alu_issue on consecutive cycles.
- Enqueue class 000 → illegal_drop=1 for one cycle, no issue flag asserted, count decrements.
- With 5 entries queued, assert flush together with in_valid → count=0 and in_ready=1 next cycle, and the flush-cycle enqueue is not present. A busy multiplier still shows mult_busy until its count expires.
